// File: rtl/pipelined_adder_pkg.sv
// rtl/pipelined_adder_pkg.sv - chunk geometry helpers shared by the pipelined adder
//
// Purpose: derive how a WIDTH-bit word is cut into STAGES ripple segments.
//   chunk_width : CHUNK = ceil(WIDTH/STAGES), bits per segment
//   chunk_lo    : index of the lowest bit handled by segment k
//   chunk_len   : bits actually owned by segment k (top one may be short or empty)
// Ports: none (package).

package pipelined_adder_pkg;

    function automatic int chunk_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int chunk_lo(input int k, input int width, input int stages);
        return k * chunk_width(width, stages);
    endfunction

    // A segment starting at or beyond WIDTH owns no bits and only forwards its carry.
    function automatic int chunk_len(input int k, input int width, input int stages);
        int lo;
        int cw;
        lo = chunk_lo(k, width, stages);
        cw = chunk_width(width, stages);
        if (lo >= width) begin
            return 0;
        end
        if (width - lo < cw) begin
            return width - lo;
        end
        return cw;
    endfunction

endpackage

// File: rtl/pipelined_adder_chunk_stage.sv
// rtl/pipelined_adder_chunk_stage.sv - combinational ripple-carry add of one chunk
//
// Module adder_chunk_stage, purely combinational.
// Ports:
//   a_chunk, b_chunk [CW-1:0] : operand slices
//   carry_in                  : carry into bit 0 of the slice
//   sum_chunk [CW-1:0]        : slice sum
//   carry_out                 : carry out of the slice MSB
//   carry_into_msb            : carry into the slice MSB (used for signed overflow)

module adder_chunk_stage #(
    parameter int CW = 1
) (
    input  logic [CW-1:0] a_chunk,
    input  logic [CW-1:0] b_chunk,
    input  logic          carry_in,
    output logic [CW-1:0] sum_chunk,
    output logic          carry_out,
    output logic          carry_into_msb
);

    logic [CW:0] carry;

    always_comb begin
        carry     = '0;
        sum_chunk = '0;
        carry[0]  = carry_in;
        for (int i = 0; i < CW; i++) begin
            sum_chunk[i] = a_chunk[i] ^ b_chunk[i] ^ carry[i];
            carry[i+1]   = (a_chunk[i] & b_chunk[i]) | (carry[i] & (a_chunk[i] ^ b_chunk[i]));
        end
    end

    assign carry_out      = carry[CW];
    assign carry_into_msb = carry[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit adder split into STAGES registered ripple chunks
//
// Purpose: pipelined add with one chunk of ripple per cycle, ready/valid on both
//   sides, full backpressure, latency STAGES, throughput one result per cycle.
// Optional feature: define PIPELINED_ADDER_SUB_EN to add the 'sub' input
//   (a - b - cin when sub=1; cout=1 means no borrow).
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready = !out_valid || out_ready)
//   a, b [WIDTH-1:0]    : operands
//   cin                 : carry into bit 0
//   sub                 : subtract select (only with PIPELINED_ADDER_SUB_EN)
//   out_valid/out_ready : result handshake
//   sum [WIDTH-1:0]     : result, modulo 2^WIDTH
//   cout                : carry out of the MSB
//   ovf                 : signed overflow (carry into MSB xor carry out of MSB)

module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 100,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CHUNK = chunk_width(WIDTH, STAGES);
    localparam int LAST  = STAGES - 1;

    // Stage k registers hold the transaction after chunk k has been added:
    // the still-needed operand bits (skew), the finished sum bits (deskew),
    // the chunk carry-out and the carry into the word MSB seen so far.
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic             valid_nxt [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic             carry_nxt [STAGES];
    logic             cmsb_q [STAGES];
    logic             cmsb_d [STAGES];
    logic             cmsb_nxt [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] a_nxt [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] b_nxt [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic [WIDTH-1:0] sum_nxt [STAGES];

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    // The pipeline moves as a whole; a held output freezes every stage.
    assign advance  = !valid_q[LAST] || out_ready;
    assign in_ready = advance;

`ifdef PIPELINED_ADDER_SUB_EN
    // Subtraction is a + ~b + ~cin; inverting at entry keeps the pipeline add-only.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub ? ~cin : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO   = k * CHUNK;
        localparam int CW_K = chunk_len(k, WIDTH, STAGES);

        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic             c_in;
        logic             v_in;
        logic [WIDTH-1:0] sum_out;
        logic             carry_out_k;
        logic             cmsb_out_k;

        if (k == 0) begin : g_first
            assign a_in   = a;
            assign b_in   = b_eff;
            assign sum_in = '0;
            assign c_in   = cin_eff;
            assign v_in   = in_valid;
        end else begin : g_next
            assign a_in   = a_q[k-1];
            assign b_in   = b_q[k-1];
            assign sum_in = sum_q[k-1];
            assign c_in   = carry_q[k-1];
            assign v_in   = valid_q[k-1];
        end

        if (CW_K > 0) begin : g_add
            logic [CW_K-1:0] s_chunk;
            logic            c_out;
            logic            c_msb;

            adder_chunk_stage #(
                .CW(CW_K)
            ) u_chunk (
                .a_chunk        (a_in[LO +: CW_K]),
                .b_chunk        (b_in[LO +: CW_K]),
                .carry_in       (c_in),
                .sum_chunk      (s_chunk),
                .carry_out      (c_out),
                .carry_into_msb (c_msb)
            );

            always_comb begin
                sum_out                 = sum_in;
                sum_out[LO +: CW_K]     = s_chunk;
            end

            assign carry_out_k = c_out;
            // Every non-empty chunk overwrites this; the last one owns the word MSB,
            // and empty chunks above it only forward, so the value reaching the
            // output is the carry into bit WIDTH-1.
            assign cmsb_out_k  = c_msb;
        end else begin : g_pass
            // Empty chunks only exist above the first, so k-1 is always valid here.
            assign sum_out     = sum_in;
            assign carry_out_k = c_in;
            assign cmsb_out_k  = cmsb_q[k-1];
        end

        assign a_nxt[k]     = a_in;
        assign b_nxt[k]     = b_in;
        assign sum_nxt[k]   = sum_out;
        assign carry_nxt[k] = carry_out_k;
        assign cmsb_nxt[k]  = cmsb_out_k;
        assign valid_nxt[k] = v_in;
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            valid_d[k] = valid_q[k];
            carry_d[k] = carry_q[k];
            cmsb_d[k]  = cmsb_q[k];
            a_d[k]     = a_q[k];
            b_d[k]     = b_q[k];
            sum_d[k]   = sum_q[k];
            if (advance) begin
                valid_d[k] = valid_nxt[k];
                carry_d[k] = carry_nxt[k];
                cmsb_d[k]  = cmsb_nxt[k];
                a_d[k]     = a_nxt[k];
                b_d[k]     = b_nxt[k];
                sum_d[k]   = sum_nxt[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
                carry_q[k] <= 1'b0;
                cmsb_q[k]  <= 1'b0;
                a_q[k]     <= '0;
                b_q[k]     <= '0;
                sum_q[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= valid_d[k];
                carry_q[k] <= carry_d[k];
                cmsb_q[k]  <= cmsb_d[k];
                a_q[k]     <= a_d[k];
                b_q[k]     <= b_d[k];
                sum_q[k]   <= sum_d[k];
            end
        end
    end

    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = carry_q[LAST];
    assign ovf       = cmsb_q[LAST] ^ carry_q[LAST];

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - randomized scoreboard bench for pipelined_adder

module tb_pipelined_adder;

    localparam int W  = 100;
    localparam int ST = 4;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    logic         s_in_valid;
    logic         s_in_ready;
    logic [9:0]   s_a;
    logic [9:0]   s_b;
    logic         s_cin;
    logic         s_out_valid;
    logic         s_out_ready;
    logic [9:0]   s_sum;
    logic         s_cout;
    logic         s_ovf;

    int   cmp_n = 0;
    int   err_n = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (sub_i),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    pipelined_adder #(.WIDTH(10), .STAGES(3)) dut_small (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .a         (s_a),
        .b         (s_b),
        .cin       (s_cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .sum       (s_sum),
        .cout      (s_cout),
        .ovf       (s_ovf)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        cmp_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full-precision arithmetic, signed overflow from operand/result signs.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic sb);
        logic [W:0]   full;
        logic [W-1:0] ye;
        logic         ce;
        exp_t         e;
        ye   = sb ? ~y : y;
        ce   = sb ? ~c : c;
        full = {1'b0, x} + {1'b0, ye} + {{W{1'b0}}, ce};
        e.s  = full[W-1:0];
        e.co = full[W];
        e.ov = (x[W-1] == ye[W-1]) && (full[W-1] != x[W-1]);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [127:0] r;
        logic [W-1:0] v;
        r = {$urandom, $urandom, $urandom, $urandom};
        v = r[W-1:0];
        case ($urandom_range(0, 7))
            0: v = '1;
            1: v = '0;
            2: begin v = '0; v[W-1] = 1'b1; end
            3: begin v = '1; v[W-1] = 1'b0; end
            default: ;
        endcase
        return v;
    endfunction

    // Scoreboard: every cycle with out_valid, the result must equal the oldest
    // accepted transaction; it is retired only when out_ready consumes it.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    cmp_n++;
                    err_n++;
                    $display("FAIL unexpected_output: got sum=%h cout=%b ovf=%b expected no result",
                             sum, cout, ovf);
                end else begin
                    e = exp_q[0];
                    check("scoreboard_result", {sum, cout, ovf}, {e.s, e.co, e.ov});
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub_i));
            end
        end
    end

    task automatic directed(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                            input logic tc, input logic ts, input logic [W-1:0] es,
                            input logic eco, input logic eov);
        int lat;
        a = ta; b = tb_v; cin = tc; sub_i = ts;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; sub_i = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, ST);
        check({name, "_sum"}, sum, es);
        check({name, "_cout"}, cout, eco);
        check({name, "_ovf"}, ovf, eov);
    endtask

    task automatic small_txn(input string name, input logic [9:0] x, input logic [9:0] y, input logic c);
        logic [10:0] full;
        logic        eov;
        int          lat;
        full = {1'b0, x} + {1'b0, y} + {10'd0, c};
        eov  = (x[9] == y[9]) && (full[9] != x[9]);
        check({name, "_in_ready"}, s_in_ready, 1'b1);
        s_a = x; s_b = y; s_cin = c; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 1;
        while (!s_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_result"}, {s_sum, s_cout, s_ovf}, {full[9:0], full[10], eov});
    endtask

    initial begin
        logic [W-1:0] v;
        logic [W-1:0] ta [8];
        logic [W-1:0] tbv [8];
        logic         tc [8];
        int           idx;
        logic         acc;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0; sub_i = 1'b0;
        s_in_valid = 1'b0; s_out_ready = 1'b1; s_a = '0; s_b = '0; s_cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_result", {sum, cout, ovf}, '0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_small_out_valid", s_out_valid, 1'b0);

        // Hand-computed corner cases.
        v = '0; v[0] = 1'b1;
        directed("allones_plus1", '1, v, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        v = '0; v[W-1] = 1'b1;
        directed("maxpos_plus1", v - 1, 100'd1, 1'b0, 1'b0, v, 1'b0, 1'b1);
        directed("minneg_twice", v, v, 1'b0, 1'b0, '0, 1'b1, 1'b1);
        directed("small_values", 100'd1234, 100'd4321, 1'b1, 1'b0, 100'd5556, 1'b0, 1'b0);
`ifdef PIPELINED_ADDER_SUB_EN
        v = '1;
        directed("sub_5_minus_7", 100'd5, 100'd7, 1'b0, 1'b1, v - 1, 1'b0, 1'b0);
`endif

        // Back-to-back stream: results at relative cycles 4..11, never stalled.
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) begin
            ta[i] = rnd_op(); tbv[i] = rnd_op(); tc[i] = 1'($urandom_range(0, 1));
        end
        a = ta[0]; b = tbv[0]; cin = tc[0]; in_valid = 1'b1;
        for (int rel = 1; rel <= 14; rel++) begin
            @(posedge clk); #1;
            check("b2b_out_valid", out_valid, (rel >= 4 && rel <= 11));
            check("b2b_in_ready", in_ready, 1'b1);
            if (rel < 8) begin
                a = ta[rel]; b = tbv[rel]; cin = tc[rel];
            end else begin
                in_valid = 1'b0;
            end
        end

        // Same kind of stream with the consumer stalled for three cycles.
        for (int i = 0; i < 8; i++) begin
            ta[i] = rnd_op(); tbv[i] = rnd_op(); tc[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = !(c >= 5 && c < 8);
            if (idx < 8) begin
                in_valid = 1'b1; a = ta[idx]; b = tbv[idx]; cin = tc[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c >= 5 && c < 8) begin
                check("stall_out_valid", out_valid, 1'b1);
                check("stall_in_ready", in_ready, 1'b0);
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("stall_all_accepted", idx, 8);
        check("stall_drained", exp_q.size(), 0);

        // Reset with three transactions in flight.
        out_ready = 1'b1;
        for (int rel = 0; rel < 3; rel++) begin
            a = rnd_op(); b = rnd_op(); cin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midreset_out_valid", out_valid, 1'b0);
        check("midreset_result", {sum, cout, ovf}, '0);
        check("midreset_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("midreset_no_stale", out_valid, 1'b0);
        end

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = rnd_op(); b = rnd_op(); cin = 1'($urandom_range(0, 1));
`ifdef PIPELINED_ADDER_SUB_EN
            sub_i = 1'($urandom_range(0, 1));
`endif
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1; sub_i = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("random_drained", exp_q.size(), 0);

        // Uneven split: 10 bits over 3 stages gives chunks of 4, 4 and 2.
        small_txn("small_1023_1_1", 10'd1023, 10'd1, 1'b1);
        check("small_literal_sum", s_sum, 10'd1);
        check("small_literal_cout", s_cout, 1'b1);
        for (int i = 0; i < 6; i++) begin
            small_txn("small_random", 10'($urandom), 10'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
        $finish;
    end

endmodule
